// File: rtl/regfile_pkg.sv
// Shared sizing and FSM encoding for the register-file dump sequencer.
package regfile_pkg;

  localparam int DW    = 16;
  localparam int AW    = 3;
  localparam int NREGS = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    PRESENT = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/regfile.sv
// Small register file: synchronous write, combinational read.
// No reset on storage; contents are defined only after being written.
module regfile #(
  parameter int DW = 16,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          write,
  input  logic [AW-1:0] writenum,
  input  logic [DW-1:0] data_in,
  input  logic [AW-1:0] readnum,
  output logic [DW-1:0] data_out
);

  logic [DW-1:0] regs [1<<AW];

  always_ff @(posedge clk) begin
    if (write) regs[writenum] <= data_in;
  end

  assign data_out = regs[readnum];

endmodule

// File: rtl/regfile_dump.sv
// Sweeps count registers from base (wrapping), presenting each on a valid/ready port.
// Two cycles per word minimum; out_ready low holds the word, index and readnum frozen.
module regfile_dump #(
  parameter int DW = regfile_pkg::DW,
  parameter int AW = regfile_pkg::AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] base,
  input  logic [AW:0]   count,
  output logic [AW-1:0] readnum,
  input  logic [DW-1:0] rf_data,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] out_idx,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic          done
);

  import regfile_pkg::*;

  state_t        state;
  state_t        state_nxt;
  logic [AW:0]   remaining;
  logic [AW:0]   count_clamped;

  assign count_clamped = (count > (AW+1)'(NREGS)) ? (AW+1)'(NREGS) : count;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (count == '0) ? DONE : READ;
      READ:    state_nxt = PRESENT;
      PRESENT: if (out_ready) state_nxt = (remaining > (AW+1)'(1)) ? READ : DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // Datapath registers; in PRESENT they only move on an accepted handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      readnum   <= '0;
      out_data  <= '0;
      out_idx   <= '0;
      out_valid <= 1'b0;
      remaining <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && count != '0) begin
            readnum   <= base;
            remaining <= count_clamped;
          end
        end
        READ: begin
          out_data  <= rf_data;
          out_idx   <= readnum;
          out_valid <= 1'b1;
        end
        PRESENT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (remaining > (AW+1)'(1)) begin
              readnum   <= readnum + AW'(1);
              remaining <= remaining - (AW+1)'(1);
            end else begin
              remaining <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench: dumps a preloaded regfile through regfile_dump and checks every word.
module tb_regfile_dump;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  base;
  logic [3:0]  count;
  logic [2:0]  readnum;
  logic [15:0] rf_data;
  logic [15:0] out_data;
  logic [2:0]  out_idx;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;

  logic        write;
  logic [2:0]  writenum;
  logic [15:0] data_in;

  int tests;
  int fails;
  int ndone;
  int stall_left;
  int stalls_seen;
  logic finished;
  logic found;

  logic [2:0]  got_idx[$];
  logic [15:0] got_dat[$];
  logic [2:0]  exp_idx[$];
  logic [15:0] exp_dat[$];
  logic [15:0] preload[8];

  regfile #(.DW(16), .AW(3)) u_rf (
    .clk      (clk),
    .write    (write),
    .writenum (writenum),
    .data_in  (data_in),
    .readnum  (readnum),
    .data_out (rf_data)
  );

  regfile_dump #(.DW(16), .AW(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base      (base),
    .count     (count),
    .readnum   (readnum),
    .rf_data   (rf_data),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one sweep with out_ready high, optionally stalling on one index and
  // optionally pulsing a second start while busy.
  task automatic run_sweep(input logic [2:0] b, input logic [3:0] c,
                           input int stall_idx, input logic [15:0] stall_dat,
                           input int restart_cyc);
    got_idx.delete();
    got_dat.delete();
    ndone = 0;
    stalls_seen = 0;
    stall_left = 5;
    finished = 1'b0;
    start = 1'b1; base = b; count = c; out_ready = 1'b1;
    step();
    start = 1'b0;
    if (c != 4'd0) begin
      chk("lat_readnum", 32'(readnum), 32'(b));
      chk("lat_valid_low", 32'(out_valid), 32'd0);
      chk("lat_busy", 32'(busy), 32'd1);
    end else begin
      chk("zero_done_now", 32'(done), 32'd1);
      chk("zero_valid", 32'(out_valid), 32'd0);
    end
    if (done) ndone++;
    step();
    if (c != 4'd0) chk("lat_valid_high", 32'(out_valid), 32'd1);
    for (int cyc = 0; cyc < 200 && !finished; cyc++) begin
      start = (cyc == restart_cyc);
      if (cyc == restart_cyc) begin base = 3'd5; count = 4'd1; end
      if (done) ndone++;
      if (out_valid && stall_idx >= 0 && out_idx == 3'(stall_idx) && stall_left > 0) begin
        out_ready = 1'b0;
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data", 32'(out_data), 32'(stall_dat));
        chk("stall_idx", 32'(out_idx), 32'(stall_idx));
        stall_left--;
        stalls_seen++;
      end else begin
        out_ready = 1'b1;
      end
      if (out_valid && out_ready) begin
        got_idx.push_back(out_idx);
        got_dat.push_back(out_data);
      end
      if (ndone > 0 && !busy) finished = 1'b1;
      if (!finished) step();
    end
    start = 1'b0;
    out_ready = 1'b1;
    chk("sweep_finished", 32'(finished), 32'd1);
    chk("done_pulses", 32'(ndone), 32'd1);
    chk("idle_after", 32'(busy), 32'd0);
    if (stall_idx >= 0) chk("stall_cycles", 32'(stalls_seen), 32'd5);
  endtask

  task automatic compare_words(input string tag);
    chk({tag, "_nwords"}, 32'(got_idx.size()), 32'(exp_idx.size()));
    for (int k = 0; k < exp_idx.size() && k < got_idx.size(); k++) begin
      chk({tag, "_idx"}, 32'(got_idx[k]), 32'(exp_idx[k]));
      chk({tag, "_dat"}, 32'(got_dat[k]), 32'(exp_dat[k]));
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    write = 1'b0; writenum = 3'd0; data_in = 16'd0;
    preload = '{16'd1, 16'd3, 16'd7, 16'd15, 16'd31, 16'd63, 16'd127, 16'd255};

    // Reset held together with start: reset must win.
    reset = 1'b1; start = 1'b1; base = 3'd3; count = 4'd4; out_ready = 1'b1;
    step();
    step();
    chk("rst_readnum", 32'(readnum), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_idx", 32'(out_idx), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    reset = 1'b0; start = 1'b0;

    for (int i = 0; i < 8; i++) begin
      write = 1'b1; writenum = 3'(i); data_in = preload[i];
      step();
    end
    write = 1'b0;
    chk("idle_after_preload", 32'(busy), 32'd0);

    // Full sweep from R0.
    run_sweep(3'd0, 4'd8, -1, 16'd0, -1);
    exp_idx = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    exp_dat = '{16'd1, 16'd3, 16'd7, 16'd15, 16'd31, 16'd63, 16'd127, 16'd255};
    compare_words("full");

    // Wrap from 7 to 0.
    run_sweep(3'd6, 4'd4, -1, 16'd0, -1);
    exp_idx = '{3'd6, 3'd7, 3'd0, 3'd1};
    exp_dat = '{16'd127, 16'd255, 16'd1, 16'd3};
    compare_words("wrap");

    // Zero count: done only, no words.
    run_sweep(3'd2, 4'd0, -1, 16'd0, -1);
    exp_idx = {};
    exp_dat = {};
    compare_words("zero");

    // Backpressure on the second word.
    run_sweep(3'd0, 4'd3, 1, 16'd3, -1);
    exp_idx = '{3'd0, 3'd1, 3'd2};
    exp_dat = '{16'd1, 16'd3, 16'd7};
    compare_words("stall");

    // Count above 8 clamps to 8.
    run_sweep(3'd4, 4'd12, -1, 16'd0, -1);
    exp_idx = '{3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2, 3'd3};
    exp_dat = '{16'd31, 16'd63, 16'd127, 16'd255, 16'd1, 16'd3, 16'd7, 16'd15};
    compare_words("clamp");

    // Start pulsed mid-sweep must be ignored.
    run_sweep(3'd2, 4'd3, -1, 16'd0, 2);
    exp_idx = '{3'd2, 3'd3, 3'd4};
    exp_dat = '{16'd7, 16'd15, 16'd31};
    compare_words("restart");

    // Reset while presenting the third word.
    start = 1'b1; base = 3'd0; count = 4'd8; out_ready = 1'b1;
    step();
    start = 1'b0;
    found = 1'b0;
    for (int cyc = 0; cyc < 40 && !found; cyc++) begin
      if (out_valid && out_idx == 3'd2) found = 1'b1;
      else step();
    end
    chk("rst_mid_reached", 32'(found), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_readnum", 32'(readnum), 32'd0);
    chk("rst_mid_done", 32'(done), 32'd0);
    ndone = 0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      if (done || busy) ndone++;
      step();
    end
    chk("rst_mid_quiet", 32'(ndone), 32'd0);

    run_sweep(3'd3, 4'd2, -1, 16'd0, -1);
    exp_idx = '{3'd3, 3'd4};
    exp_dat = '{16'd15, 16'd31};
    compare_words("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
